// File: rtl/flasher_ctrl.sv
// flasher_ctrl: sequencer that drives boundFlasher's flick input and counts completed lamp runs
module flasher_ctrl #(
    parameter int DEBOUNCE = 16,
    parameter int START_TO = 1024,
    parameter int GAP      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_raw,
    input  logic        auto_en,
    input  logic [7:0]  auto_runs,
    input  logic        kick_en,
    input  logic [15:0] lamps,
    output logic        flick,
    output logic        busy,
    output logic        run_done,
    output logic [7:0]  runs_cnt,
    output logic        err
);
    localparam int DW = $clog2(DEBOUNCE) + 1;
    localparam int TW = $clog2(START_TO) + 1;
    localparam int GW = $clog2(GAP) + 1;
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TO - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic          btn_m, btn_s, btn_db, btn_db_q, btn_press, seq_end;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] tmo;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    state, nxt;
    logic [7:0]    rem, rem_nxt, rem_dec;
    logic [15:0]   lamps_prev;

    assign btn_press = btn_db & ~btn_db_q;
    assign seq_end   = lamps_prev == 16'hFFFF && lamps == 16'h0000;
    assign busy      = state == S_START || state == S_RUN || state == S_GAP;
    assign rem_dec   = rem == 8'd0 ? 8'd0 : rem - 8'd1;

    // synchronise the button, then let btn_db follow only after a stable run of differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_m    <= btn_raw;
            btn_s    <= btn_m;
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // next-state and remaining-run decisions
    always_comb begin
        nxt     = state;
        rem_nxt = rem;
        case (state)
            S_IDLE: begin
                if (btn_press) begin
                    nxt     = S_START;
                    rem_nxt = 8'd1;
                end else if (auto_en && auto_runs != 8'd0) begin
                    nxt     = S_START;
                    rem_nxt = auto_runs;
                end
            end
            S_START: nxt = lamps != 16'd0 ? S_RUN : (tmo == TMO_LAST ? S_ERR : S_START);
            S_RUN: begin
                if (seq_end) begin
                    rem_nxt = rem_dec;
                    nxt     = (rem_dec == 8'd0 || !auto_en) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: nxt = !auto_en ? S_IDLE : (gap_cnt == GAP_LAST ? S_START : S_GAP);
            S_ERR: nxt = S_ERR;
            default: nxt = S_IDLE;
        endcase
    end

    // state, per-state counters, registered flick and run bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rem        <= 8'd0;
            tmo        <= '0;
            gap_cnt    <= '0;
            flick      <= 1'b0;
            run_done   <= 1'b0;
            runs_cnt   <= 8'd0;
            err        <= 1'b0;
            lamps_prev <= 16'd0;
        end else begin
            state      <= nxt;
            rem        <= rem_nxt;
            lamps_prev <= lamps;
            tmo        <= (state == S_START && nxt == S_START) ? tmo + 1'b1 : '0;
            gap_cnt    <= (state == S_GAP && nxt == S_GAP) ? gap_cnt + 1'b1 : '0;
            flick      <= nxt == S_START || (nxt == S_RUN && kick_en && btn_db);
            run_done   <= state == S_RUN && seq_end;
            if (state == S_RUN && seq_end && runs_cnt != 8'hFF)
                runs_cnt <= runs_cnt + 8'd1;
            if (nxt == S_ERR)
                err <= 1'b1;
        end
    end
endmodule
